fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage for the single-issue CPU. It sits directly upstream of the control unit.
//  - Owns the PC.
//  - Issues instruction-memory reads over a valid/ready handshake.
//  - Holds the fetched word in the IF/ID register that the control unit decodes.
//  - Handles downstream stall, branch/jump redirect and a HALT instruction.
// PARAMETERS
//  ADDR_WIDTH   32            PC / instruction-memory address width
//  INSTR_WIDTH  32            instruction word width
//  RESET_PC     'h0000_0000   PC value loaded by reset (word aligned)
//  HALT_OPCODE  6'b111111     value of instr[31:26] that halts fetch
// PORTS
//  clk          in   1            rising-edge clock, sole clock
//  reset        in   1            synchronous, active-high reset
//  imem_req     out  1            read request valid
//  imem_addr    out  ADDR_WIDTH   read address (= PC, bits[1:0] always 0)
//  imem_ready   in   1            memory accepts request; imem_rdata valid same cycle
//  imem_rdata   in   INSTR_WIDTH  instruction word
//  stall        in   1            decode cannot consume IF/ID entry this cycle
//  redirect     in   1            branch/jump taken: flush and refetch
//  redirect_pc  in   ADDR_WIDTH   new PC (bits[1:0] ignored, treated as 0)
//  if_id_instr  out  INSTR_WIDTH  fetched instruction to control unit
//  if_id_pc     out  ADDR_WIDTH   address of if_id_instr
//  if_id_valid  out  1            IF/ID entry holds a live instruction
//  halted       out  1            fetch stopped on HALT_OPCODE
//  fetch_count  out  32           instructions accepted since reset
// BEHAVIOUR
//  Reset (sync, high): state=BOOT, PC=RESET_PC, imem_req=0, if_id_instr=0, if_id_pc=0,
//   if_id_valid=0, halted=0, fetch_count=0. Reset mid-transfer discards everything in flight.
//  FSM states:
//   - BOOT: one idle cycle after reset deasserts, imem_req=0; next state RUN.
//   - RUN: fetching.
//   - HALTED: imem_req=0, halted=1.
//  imem_req (combinational) = (state==RUN) & ~redirect & (~if_id_valid | ~stall).
//  imem_addr = PC at all times.
//  Handshake: transfer when imem_req & imem_ready in the same cycle. Dropping imem_req
//   without ready is legal (no outstanding transactions). imem_ready while imem_req=0 is ignored.
//  On transfer, at the next edge:
//   - if_id_instr<=imem_rdata, if_id_pc<=PC, if_id_valid<=1.
//   - PC<=PC+4, modulo 2^ADDR_WIDTH (wraps to 0).
//   - fetch_count++, saturating at 32'hFFFF_FFFF.
//  Latency: instruction appears on IF/ID one cycle after its handshake cycle.
//   Throughput is 1 instr/cycle with imem_ready tied high.
//  No transfer, stall=0: if_id_valid<=0; bubble, contents undefined-but-stable.
//  No transfer, stall=1: all IF/ID outputs hold their values.
//  Redirect (highest priority below reset, any state except BOOT):
//   - PC<={redirect_pc[ADDR_WIDTH-1:2],2'b00}.
//   - if_id_valid<=0.
//   - No transfer this cycle (imem_req forced 0).
//   - Overrides stall and any simultaneous halt.
//   - From HALTED, next state RUN and halted<=0 (the halt was on a squashed path).
//  HALT: transfer of a word with rdata[31:26]==HALT_OPCODE:
//   - Latched into IF/ID normally, PC advances.
//   - Next state HALTED, halted<=1. Only reset or redirect leave HALTED.
//  IF/ID stall while valid blocks new requests, so no entry is ever overwritten or lost.
// TESTING
//  Reset, imem_ready=1, stall=0, memory = sequential words 'h0,'h4... tagged with addr
//   -> BOOT cycle, then imem_addr 0,4,8,C on consecutive cycles; if_id_pc lags imem_addr by 1; fetch_count increments.
//  imem_ready low 3 cycles at addr 'h8 -> imem_addr held 'h8, if_id_valid=0 for those cycles, then 'h8 delivered once.
//  Stall=1 for 2 cycles with if_id_pc='h4 valid -> imem_req=0, IF/ID holds 'h4; stall drop -> 'h8 next cycle, no loss/duplicate.
//  Redirect to 'h103 coincident with a transfer at 'h10 and stall=1 -> 'h10 discarded, if_id_valid=0 next cycle, imem_addr='h100.
//  Fetch 'hFC00_0000 (HALT) at 'h20 -> IF/ID holds it, halted=1, imem_req=0 indefinitely.
//   Then redirect to 'h40 -> RUN, fetch resumes at 'h40.
//  RESET_PC='hFFFF_FFFC -> second fetch address 'h0 (wrap).
//   Assert reset while stalled with valid=1 -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a valid/ready handshake
// and holds the fetched word in the IF/ID register, with stall, redirect and HALT handling.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDR_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0]   r_if_id_instr;
  logic [ADDR_WIDTH-1:0]    r_if_id_pc;
  logic                     r_if_id_valid;
  logic [31:0]              r_fetch_count;

  logic                     w_redirect;
  logic                     w_xfer;
  logic                     w_halt_hit;
  logic [ADDR_WIDTH-1:0]    w_redirect_pc;

  // Redirect is meaningless during the post-reset idle cycle, so it is masked there.
  assign w_redirect    = redirect & (r_state != S_BOOT);
  assign w_redirect_pc = redirect_pc & ~ADDR_WIDTH'(3);

  assign imem_req   = (r_state == S_RUN) & ~redirect & (~r_if_id_valid | ~stall);
  assign imem_addr  = r_pc;
  assign w_xfer     = imem_req & imem_ready;
  assign w_halt_hit = w_xfer & (imem_rdata[31:26] == HALT_OPCODE);

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:   w_state_nxt = S_RUN;
      S_RUN:    if (w_halt_hit) w_state_nxt = S_HALTED;
      S_HALTED: if (w_redirect) w_state_nxt = S_RUN;
      default:  w_state_nxt = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= '0;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else if (w_redirect) begin
      r_pc          <= w_redirect_pc;
      r_if_id_valid <= 1'b0;
    end else if (w_xfer) begin
      r_if_id_instr <= imem_rdata;
      r_if_id_pc    <= r_pc;
      r_if_id_valid <= 1'b1;
      r_pc          <= r_pc + ADDR_WIDTH'(4);
      if (r_fetch_count != 32'hFFFF_FFFF) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end else if (!stall) begin
      // Bubble: contents are left as they were, only the valid flag drops.
      r_if_id_valid <= 1'b0;
    end
  end

  assign if_id_instr = r_if_id_instr;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_valid = r_if_id_valid;
  assign halted      = (r_state == S_HALTED);
  assign fetch_count = r_fetch_count;

endmodule
